vmem_port_arbiter: RTL and testbench
====================================

// Module: vmem_port_arbiter
// PURPOSE
//  Shares the 128-bit vector port B of the data RAM between two requesters:
//  - the processor's vector load/store unit (CPU);
//  - the audio sample DMA, which streams FIR input/output blocks.
//  CPU has fixed priority. A starvation counter guarantees DMA progress.
//  A tagged read-latency pipe returns read data to the requester that issued it.
//  Sits between processor/DMA and the port-B pins of the data RAM; port A (scalar, 8-bit) is untouched.
// PARAMETERS
//  ADDR_W      15   port-B word address width
//  DATA_W      128  port-B data width (16 x 8-bit lanes)
//  RD_LAT      2    RAM read latency in cycles, address to q_b valid (>=1)
//  STARVE_MAX  8    cycles a pending DMA request may be refused before DMA is forced
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  reset       in   1       synchronous, active-high
//  cpu_req     in   1       CPU vector access request; held until cpu_gnt
//  cpu_we      in   1       1=write, 0=read
//  cpu_addr    in   ADDR_W  word address
//  cpu_wdata   in   DATA_W  write data
//  cpu_gnt     out  1       access accepted this cycle
//  cpu_stall   out  1       cpu_req & ~cpu_gnt; freezes processor pipeline
//  cpu_rvalid  out  1       cpu_rdata valid (one-cycle pulse)
//  cpu_rdata   out  DATA_W  read data
//  dma_req/dma_we/dma_addr/dma_wdata/dma_gnt/dma_rvalid/dma_rdata  same as cpu_* for DMA
//  ram_addr    out  ADDR_W  to RAM address_b
//  ram_wdata   out  DATA_W  to RAM data_b
//  ram_wren    out  1       to RAM wren_b
//  ram_q       in   DATA_W  from RAM q_b
// BEHAVIOUR
//  - Reset values: starve_cnt=0; state=ARB_CPU; tag pipe cleared.
//    Outputs during reset: all gnt/rvalid/ram_wren = 0; rdata = 0.
//  - Arbitration is combinational, at most one grant per cycle. The winner's
//    addr/wdata/we drive ram_*. ram_wren = winner_we & grant.
//  - With no grant: ram_wren=0, and ram_addr holds its last registered value.
//  - FSM states:
//    - ARB_CPU: cpu_req wins; otherwise dma_req wins.
//    - ARB_DMA_FORCE: dma_req wins even if cpu_req is set. Exits to ARB_CPU
//      after exactly one DMA grant.
//  - starve_cnt increments each cycle dma_req & ~dma_gnt, saturating at STARVE_MAX.
//  - starve_cnt clears on dma_gnt or ~dma_req.
//  - Enter ARB_DMA_FORCE the cycle after starve_cnt reaches STARVE_MAX-1 with
//    another refusal, i.e. DMA waits at most STARVE_MAX cycles.
//  - Handshake: the requester holds req/we/addr/wdata stable until gnt.
//    Transfer occurs on the cycle req & gnt. Dropping req before gnt is legal;
//    no access is issued.
//  - Reads:
//    - Each granted read pushes {valid=1, owner} into an RD_LAT-deep shift pipe.
//    - When an entry exits, the owner's rvalid pulses for one cycle with
//      rdata=ram_q. The other requester's rvalid stays 0.
//    - Back-to-back reads sustain one per cycle.
//  - Writes produce no rvalid. A write granted the cycle after a read to the
//    same address does not corrupt that read (RAM old-data semantics).
//  - Reset mid-operation: in-flight reads are discarded; no rvalid after reset
//    rises; starve_cnt and state return to reset values.
//  - cpu_rdata/dma_rdata are held between pulses (registered outputs).
// STRUCTURE
//  - Package vmem_arb_pkg:
//    - typedef enum logic {OWN_CPU, OWN_DMA} owner_e;
//    - typedef enum logic {ARB_CPU, ARB_DMA_FORCE} arb_state_e;
//    - struct rd_tag_t {valid, owner_e owner}.
//  - Sub-module vmem_rd_tag_pipe: RD_LAT-deep shift register of rd_tag_t with
//    synchronous clear.
//  - Arbiter FSM, starvation counter and output muxes live in vmem_port_arbiter.
// TESTING
//  1. CPU-only read at addr 0x0010 with RAM preloaded 128'hA5..A5:
//     cpu_gnt same cycle; cpu_rvalid exactly 2 cycles later with rdata A5..A5;
//     dma_rvalid stays 0.
//  2. Simultaneous cpu_req and dma_req on the same cycle, both reads:
//     CPU granted first; DMA granted next cycle once cpu_req drops.
//     rvalids return in order CPU then DMA, each with its own data.
//  3. Continuous cpu_req for 20 cycles with dma_req held:
//     DMA granted on cycle 9 (after 8 refusals); cpu_stall=1 that cycle only;
//     CPU resumes on cycle 10; starve_cnt=0 after the grant.
//  4. DMA write 0x0020 <= 128'h0123..CDEF, then CPU read 0x0020 next cycle:
//     ram_wren=1 for one cycle only; cpu_rdata == 0123..CDEF.
//  5. Two CPU reads in flight, reset asserted for 1 cycle:
//     no cpu_rvalid on any later cycle; all gnt=0 during reset;
//     first post-reset request is granted normally.
//  6. Requester drops dma_req before its grant:
//     no RAM access, ram_wren=0, starve_cnt cleared to 0.

Source files
------------

// File: rtl/vmem_arb_pkg.sv
// Shared types for the vector port-B arbiter: requester identity, arbiter
// states and the read-return tag carried alongside each outstanding read.
// Imported by vmem_rd_tag_pipe and vmem_port_arbiter.
package vmem_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    typedef enum logic {
        ARB_CPU       = 1'b0,
        ARB_DMA_FORCE = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, owner: OWN_CPU};

endpackage

// File: rtl/vmem_rd_tag_pipe.sv
// Read-return tag pipe: DEPTH-stage shift register of rd_tag_t, one entry per
// cycle, synchronous clear. Ports: clk, reset, tag_i (entry pushed this
// cycle, valid=0 when no read issued), tag_o (entry issued DEPTH cycles ago).
module vmem_rd_tag_pipe
    import vmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RD_TAG_IDLE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vmem_port_arbiter.sv
// Shares data-RAM port B between the CPU vector LSU and the audio DMA.
// Ports: cpu_*/dma_* request/grant/read-return per requester; ram_* drive the
// RAM port-B pins. CPU has fixed priority; a starvation counter forces a DMA
// grant after STARVE_MAX consecutive refusals. Read data returns RD_LAT
// cycles after the grant to whichever requester issued the read.
module vmem_port_arbiter
    import vmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic              cpu_win;
    logic              dma_win;
    logic              dma_refused;
    rd_tag_t           tag_in;
    rd_tag_t           tag_out;

    // Grant selection. Nothing is granted while reset is high.
    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (!reset) begin
            if (state_q == ARB_DMA_FORCE && dma_req) begin
                dma_win = 1'b1;
            end else if (cpu_req) begin
                cpu_win = 1'b1;
            end else if (dma_req) begin
                dma_win = 1'b1;
            end
        end
    end

    assign cpu_gnt   = cpu_win;
    assign dma_gnt   = dma_win;
    assign cpu_stall = cpu_req & ~cpu_win;

    // Idle cycles keep the previous address/data on the pins so the RAM
    // inputs do not toggle needlessly.
    always_comb begin
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if (cpu_win) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (dma_win) begin
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
        end
    end

    assign ram_wren = (cpu_win & cpu_we) | (dma_win & dma_we);

    // Starvation counter and force-state FSM.
    assign dma_refused = dma_req & ~dma_win;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (dma_refused) begin
            starve_d = (starve_q == CNT_W'(STARVE_MAX)) ? starve_q
                                                        : starve_q + CNT_W'(1);
            // This refusal is the STARVE_MAX-th in a row: force DMA next cycle.
            if (starve_q >= CNT_W'(STARVE_MAX - 1)) begin
                state_d = ARB_DMA_FORCE;
            end
        end else begin
            starve_d = '0;
        end
        // Leave force mode after the DMA grant, or if DMA gave up waiting,
        // so the CPU is never locked out by a withdrawn request.
        if (state_q == ARB_DMA_FORCE && (dma_win || !dma_req)) begin
            state_d = ARB_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_CPU;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= ram_addr;
            wdata_q  <= ram_wdata;
        end
    end

    // Read-return tagging: writes push an empty tag.
    always_comb begin
        tag_in       = RD_TAG_IDLE;
        tag_in.valid = (cpu_win & ~cpu_we) | (dma_win & ~dma_we);
        tag_in.owner = dma_win ? OWN_DMA : OWN_CPU;
    end

    vmem_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign cpu_rvalid = ~reset & tag_out.valid & (tag_out.owner == OWN_CPU);
    assign dma_rvalid = ~reset & tag_out.valid & (tag_out.owner == OWN_DMA);

    // Return data passes straight from ram_q during the pulse and is held in
    // a register afterwards; forced to zero while reset is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= ram_q;
            if (dma_rvalid) dma_rdata_q <= ram_q;
        end
    end

    assign cpu_rdata = reset ? '0 : (cpu_rvalid ? ram_q : cpu_rdata_q);
    assign dma_rdata = reset ? '0 : (dma_rvalid ? ram_q : dma_rdata_q);

endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Directed bench for vmem_port_arbiter with a 2-cycle-latency RAM model.
module tb_vmem_port_arbiter;
    import vmem_arb_pkg::*;

    localparam int AW = 15;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic          dma_gnt, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [DW-1:0] D_A5  = {16{8'hA5}};
    localparam logic [DW-1:0] D_5A  = {16{8'h5A}};
    localparam logic [DW-1:0] D_3C  = {16{8'h3C}};
    localparam logic [DW-1:0] D_77  = {16{8'h77}};
    localparam logic [DW-1:0] D_WR  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DW-1:0] D_NEW = {16{8'hEE}};

    always #5 clk = ~clk;

    vmem_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
    );

    // RAM model: registered address, registered output, read-old-data.
    logic          preload = 1'b1;
    logic [DW-1:0] mem [0:255];
    logic [7:0]    a1;
    always @(posedge clk) begin
        if (preload) begin
            mem[8'h10] <= D_A5;
            mem[8'h20] <= '0;
            mem[8'h30] <= D_5A;
            mem[8'h40] <= D_3C;
            mem[8'h50] <= D_77;
        end else if (ram_wren) begin
            mem[ram_addr[7:0]] <= ram_wdata;
        end
        a1    <= ram_addr[7:0];
        ram_q <= mem[a1];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset behaviour ----
        nxt(); nxt();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h10; cpu_wdata = D_NEW;
        #1;
        chk1("rst_cpu_gnt",    cpu_gnt, 1'b0);
        chk1("rst_ram_wren",   ram_wren, 1'b0);
        chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        chk ("rst_cpu_rdata",  cpu_rdata, '0);
        nxt();
        reset = 1'b0; preload = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        chk1("rst_state",  dut.state_q, ARB_CPU);
        chk ("rst_starve", 128'(dut.starve_q), '0);

        // ---- 1: CPU-only read ----
        nxt();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h10;
        #1;
        chk1("t1_cpu_gnt",   cpu_gnt, 1'b1);
        chk1("t1_cpu_stall", cpu_stall, 1'b0);
        chk ("t1_ram_addr",  128'(ram_addr), 128'h10);
        chk1("t1_ram_wren",  ram_wren, 1'b0);
        nxt();
        cpu_req = 1'b0;
        #1;
        chk1("t1_rvalid_early", cpu_rvalid, 1'b0);
        nxt(); #1;
        chk1("t1_cpu_rvalid", cpu_rvalid, 1'b1);
        chk ("t1_cpu_rdata",  cpu_rdata, D_A5);
        chk1("t1_dma_rvalid", dma_rvalid, 1'b0);
        nxt(); #1;
        chk1("t1_rvalid_pulse", cpu_rvalid, 1'b0);
        chk ("t1_rdata_held",   cpu_rdata, D_A5);
        chk ("t1_addr_held",    128'(ram_addr), 128'h10);

        // ---- 2: simultaneous requests ----
        nxt();
        cpu_req = 1'b1; cpu_addr = 15'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h40;
        #1;
        chk1("t2_cpu_gnt", cpu_gnt, 1'b1);
        chk1("t2_dma_gnt", dma_gnt, 1'b0);
        nxt();
        cpu_req = 1'b0;
        #1;
        chk1("t2_dma_gnt2", dma_gnt, 1'b1);
        chk ("t2_ram_addr", 128'(ram_addr), 128'h40);
        nxt();
        dma_req = 1'b0;
        #1;
        chk1("t2_cpu_rvalid", cpu_rvalid, 1'b1);
        chk1("t2_dma_rv_no",  dma_rvalid, 1'b0);
        chk ("t2_cpu_rdata",  cpu_rdata, D_A5);
        nxt(); #1;
        chk1("t2_dma_rvalid", dma_rvalid, 1'b1);
        chk1("t2_cpu_rv_no",  cpu_rvalid, 1'b0);
        chk ("t2_dma_rdata",  dma_rdata, D_3C);

        // ---- 3: starvation forcing ----
        nxt();
        cpu_req = 1'b1; cpu_addr = 15'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h40;
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) dma_req = 1'b0;
            #1;
            chk1("t3_dma_gnt",   dma_gnt, c == 9);
            chk1("t3_cpu_gnt",   cpu_gnt, c != 9);
            chk1("t3_cpu_stall", cpu_stall, c == 9);
            if (c == 9) begin
                chk1("t3_force_state", dut.state_q, ARB_DMA_FORCE);
                chk ("t3_starve_sat",  128'(dut.starve_q), 128'd8);
            end
            if (c == 10) chk("t3_starve_clr", 128'(dut.starve_q), '0);
            nxt();
        end
        cpu_req = 1'b0;
        nxt(); nxt(); nxt();

        // ---- 4: DMA write then CPU read same address ----
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h20; dma_wdata = D_WR;
        #1;
        chk1("t4_dma_gnt",  dma_gnt, 1'b1);
        chk1("t4_ram_wren", ram_wren, 1'b1);
        chk ("t4_ram_wdata", ram_wdata, D_WR);
        nxt();
        dma_req = 1'b0; dma_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h20;
        #1;
        chk1("t4_cpu_gnt",   cpu_gnt, 1'b1);
        chk1("t4_wren_once", ram_wren, 1'b0);
        nxt();
        cpu_req = 1'b0;
        #1;
        chk1("t4_wren_idle", ram_wren, 1'b0);
        chk1("t4_no_wr_rv",  dma_rvalid, 1'b0);
        nxt(); #1;
        chk1("t4_cpu_rvalid", cpu_rvalid, 1'b1);
        chk ("t4_cpu_rdata",  cpu_rdata, D_WR);

        // ---- 4b: write right after a read to the same address ----
        nxt();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h30;
        #1;
        nxt();
        cpu_req = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h30; dma_wdata = D_NEW;
        #1;
        chk1("t4b_wr_gnt", dma_gnt, 1'b1);
        nxt();
        dma_req = 1'b0; dma_we = 1'b0;
        #1;
        chk1("t4b_rvalid", cpu_rvalid, 1'b1);
        chk ("t4b_old_data", cpu_rdata, D_5A);
        nxt(); nxt();

        // ---- 5: reset with reads in flight ----
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h10;
        #1;
        chk1("t5_gnt_a", cpu_gnt, 1'b1);
        nxt();
        cpu_addr = 15'h30;
        #1;
        chk1("t5_gnt_b", cpu_gnt, 1'b1);
        nxt();
        reset = 1'b1; dma_req = 1'b1;
        #1;
        chk1("t5_rst_cpu_gnt", cpu_gnt, 1'b0);
        chk1("t5_rst_dma_gnt", dma_gnt, 1'b0);
        chk1("t5_rst_rvalid",  cpu_rvalid, 1'b0);
        chk1("t5_rst_wren",    ram_wren, 1'b0);
        chk ("t5_rst_rdata",   cpu_rdata, '0);
        nxt();
        reset = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        #1;
        chk1("t5_state",  dut.state_q, ARB_CPU);
        chk ("t5_starve", 128'(dut.starve_q), '0);
        for (int c = 0; c < 4; c++) begin
            chk1("t5_no_rvalid", cpu_rvalid, 1'b0);
            nxt();
        end
        cpu_req = 1'b1; cpu_addr = 15'h40;
        #1;
        chk1("t5_post_gnt", cpu_gnt, 1'b1);
        nxt();
        cpu_req = 1'b0;
        nxt(); #1;
        chk1("t5_post_rvalid", cpu_rvalid, 1'b1);
        chk ("t5_post_rdata",  cpu_rdata, D_3C);

        // ---- 6: DMA withdraws before grant ----
        nxt();
        cpu_req = 1'b1; cpu_addr = 15'h10;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h50; dma_wdata = D_NEW;
        #1;
        chk1("t6_dma_gnt_a", dma_gnt, 1'b0);
        nxt(); #1;
        chk1("t6_dma_gnt_b", dma_gnt, 1'b0);
        chk ("t6_starve_1",  128'(dut.starve_q), 128'd1);
        nxt();
        cpu_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
        #1;
        chk1("t6_dma_gnt_c", dma_gnt, 1'b0);
        chk1("t6_ram_wren",  ram_wren, 1'b0);
        nxt(); #1;
        chk ("t6_starve_clr", 128'(dut.starve_q), '0);
        chk ("t6_mem_intact", mem[8'h50], D_77);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
